macro_feed_layer4: RTL

MACRO_FEED_LAYER4 -- requirements
Module: macro_feed_layer4

---
 rtl/macro_feed_layer4_pkg.sv | 16 +
 rtl/macro_feed_layer4_sync_fifo.sv | 67 ++++++
 rtl/macro_feed_layer4.sv | 131 +++++++++++++
 3 files changed

// File: rtl/macro_feed_layer4_pkg.sv
// Shared configuration and FSM state encoding for the layer-4 CIM macro feeder.
package macro_pkg;

  localparam int MACRO_NUM  = 4;
  localparam int ROW_NUM    = 64;
  localparam int MACRO_LAT  = 3;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COMPUTE = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/macro_feed_layer4_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count; full/empty decode from the count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/macro_feed_layer4.sv
// Layer-4 CIM feeder: buffers activation frames, issues them to all macros, waits out
// the macro latency and holds results until the partial-sum stage captures them.
module macro_feed_layer4 #(
  parameter int MACRO_NUM  = macro_pkg::MACRO_NUM,
  parameter int ROW_NUM    = macro_pkg::ROW_NUM,
  parameter int MACRO_LAT  = macro_pkg::MACRO_LAT,
  parameter int FIFO_DEPTH = macro_pkg::FIFO_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [MACRO_NUM*ROW_NUM-1:0]        in_data,
  output logic                                macro_en,
  output logic [MACRO_NUM-1:0][ROW_NUM-1:0]   macro_data,
  output logic                                psum_valid,
  input  logic                                psum_ready,
  output logic                                busy,
  output logic [15:0]                         frame_cnt
);

  import macro_pkg::*;

  localparam int         FRAME_W  = MACRO_NUM * ROW_NUM;
  localparam int         CW       = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] LAT_LOAD = 4'(MACRO_LAT - 1);

  state_t             state;
  state_t             next_state;
  logic [3:0]         lat_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [FRAME_W-1:0] fifo_head;
  logic               push;
  logic               pop;
  logic               handshake;

  // No bypass: a pop in the same cycle never frees space for a push.
  assign in_ready  = !fifo_full;
  assign push      = in_valid && !fifo_full;
  assign pop       = (state == ISSUE);
  assign handshake = (state == HOLD) && psum_ready;
  assign busy      = (state != IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) next_state = ISSUE;
        else             next_state = IDLE;
      end
      ISSUE: begin
        next_state = COMPUTE;
      end
      COMPUTE: begin
        if (lat_cnt == 4'd0) next_state = HOLD;
        else                 next_state = COMPUTE;
      end
      HOLD: begin
        if (!psum_ready)     next_state = HOLD;
        else if (fifo_empty) next_state = IDLE;
        else                 next_state = ISSUE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lat_cnt <= 4'd0;
    end else begin
      state <= next_state;
      if (state == ISSUE) begin
        lat_cnt <= LAT_LOAD;
      end else if ((state == COMPUTE) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end else begin
        lat_cnt <= lat_cnt;
      end
    end
  end

  // Outputs are decoded from next_state so they align with the state register;
  // the packed macro_data layout puts in_data[m*ROW_NUM +: ROW_NUM] on macro m.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      macro_en   <= 1'b0;
      psum_valid <= 1'b0;
      macro_data <= '0;
    end else begin
      macro_en   <= (next_state == ISSUE);
      psum_valid <= (next_state == HOLD);
      if (next_state == ISSUE) begin
        macro_data <= fifo_head;
      end else begin
        macro_data <= macro_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (handshake) begin
      frame_cnt <= frame_cnt + 16'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

endmodule
